// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file port controller.
// Holds the sequencer state encoding and the operand capture/bypass rule.
package regfile_pkg;

   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_DATA_WIDTH = 32;
   localparam logic [RF_ADDR_WIDTH-1:0] REG_ZERO = '0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ISS1 = 3'd1,
      CAP1 = 3'd2,
      ISS2 = 3'd3,
      CAP2 = 3'd4,
      RSP  = 3'd5
   } rfc_state_t;

   // x0 reads as zero; a same-cycle writeback wins over the stale SRAM word.
   function automatic logic [RF_DATA_WIDTH-1:0] rf_capture(
      input logic [RF_ADDR_WIDTH-1:0] r,
      input logic                     wv,
      input logic [RF_ADDR_WIDTH-1:0] wa,
      input logic [RF_DATA_WIDTH-1:0] wd,
      input logic [RF_DATA_WIDTH-1:0] rd
   );
      if (r == REG_ZERO)
         return '0;
      else if (wv && (wa == r))
         return wd;
      else
         return rd;
   endfunction

endpackage

// File: rtl/regfile_port_ctrl.sv
// Sequences a two-operand read and a never-stalled writeback stream onto one
// single-port regfile SRAM, with x0 handling and writeback-to-operand bypass.
module regfile_port_ctrl
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_rs1,
   input  logic [ADDR_WIDTH-1:0] req_rs2,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rs1_data,
   output logic [DATA_WIDTH-1:0] rsp_rs2_data,
   input  logic                  wb_valid,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   rfc_state_t            state;
   logic [ADDR_WIDTH-1:0] r1, r2;
   logic [DATA_WIDTH-1:0] d1, d2;
   logic [DATA_WIDTH-1:0] cap1, cap2;
   logic                  hit1, hit2;

   // Writeback always owns the port; otherwise the address points at whichever
   // operand the sequencer is reading (r1 only from ISS1, r2 from CAP1/ISS2).
   assign sram_we   = rst_n && wb_valid && (wb_addr != ADDR_WIDTH'(0));
   assign sram_din  = wb_data;
   assign sram_addr = wb_valid ? wb_addr : ((state == ISS1) ? r1 : r2);

   assign cap1 = DATA_WIDTH'(rf_capture(RF_ADDR_WIDTH'(r1), wb_valid, RF_ADDR_WIDTH'(wb_addr),
                                        RF_DATA_WIDTH'(wb_data), RF_DATA_WIDTH'(sram_dout)));
   assign cap2 = DATA_WIDTH'(rf_capture(RF_ADDR_WIDTH'(r2), wb_valid, RF_ADDR_WIDTH'(wb_addr),
                                        RF_DATA_WIDTH'(wb_data), RF_DATA_WIDTH'(sram_dout)));

   // Writes landing after an operand is captured must patch the held copy.
   assign hit1 = wb_valid && (r1 != ADDR_WIDTH'(0)) && (wb_addr == r1);
   assign hit2 = wb_valid && (r2 != ADDR_WIDTH'(0)) && (wb_addr == r2);

   assign rsp_rs1_data = d1;
   assign rsp_rs2_data = d2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         r1        <= '0;
         r2        <= '0;
         d1        <= '0;
         d2        <= '0;
         rsp_valid <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  r1        <= req_rs1;
                  r2        <= req_rs2;
                  req_ready <= 1'b0;
                  state     <= ISS1;
               end
            end
            ISS1: begin
               if (!wb_valid) state <= CAP1;
            end
            CAP1: begin
               d1    <= cap1;
               state <= wb_valid ? ISS2 : CAP2;
            end
            ISS2: begin
               if (hit1) d1 <= wb_data;
               if (!wb_valid) state <= CAP2;
            end
            CAP2: begin
               if (hit1) d1 <= wb_data;
               d2        <= cap2;
               rsp_valid <= 1'b1;
               state     <= RSP;
            end
            RSP: begin
               // Writes in the handshake cycle are left to the next request.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  if (hit1) d1 <= wb_data;
                  if (hit2) d2 <= wb_data;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Initiator side of the single-port register-file SRAM interface: `we`/`addr`/`din` out, `dout` in, one-cycle synchronous read.
- Sequences a decode-stage two-operand read request (rs1, rs2) and a writeback stream onto the one SRAM port.
- Handles x0 semantics and the read-after-write hazard between the writeback port and operand reads.
- Sits between decode/writeback logic and the regfile SRAM instance.

Parameters:
- ADDR_WIDTH, 5, register index width; must equal the SRAM address width.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  operand read request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_rs1  in  ADDR_WIDTH  source register 1 index
- req_rs2  in  ADDR_WIDTH  source register 2 index
- rsp_valid  out  1  operand data valid
- rsp_ready  in  1  consumer accepts the response
- rsp_rs1_data  out  DATA_WIDTH  rs1 value
- rsp_rs2_data  out  DATA_WIDTH  rs2 value
- wb_valid  in  1  writeback; always accepted, never stalled
- wb_addr  in  ADDR_WIDTH  destination register
- wb_data  in  DATA_WIDTH  writeback data
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_din  out  DATA_WIDTH  SRAM write data
- sram_dout  in  DATA_WIDTH  SRAM read data; valid the cycle after a read is issued; holds through write cycles

Behaviour:
- Writeback owns the SRAM port. Whenever wb_valid=1:
  - sram_addr=wb_addr, sram_din=wb_data.
  - sram_we=(wb_addr!=0); writes to x0 are dropped.
- A read is issued only in a cycle with wb_valid=0: sram_we=0, sram_addr=register index.
- sram_* are combinational from state and wb inputs. sram_we=0 while rst_n=0.
- State register in states IDLE, ISS1, CAP1, ISS2, CAP2, RSP. Latched r1, r2 indices; d1, d2 data registers.
- IDLE:
  - req_ready=1.
  - On accept, latch r1/r2 → ISS1.
- ISS1: if !wb_valid, issue read r1 → CAP1; else stay.
- CAP1:
  - Capture d1 = (r1==0) ? 0 : (wb_valid && wb_addr==r1) ? wb_data : sram_dout.
  - If !wb_valid, issue read r2 → CAP2; else → ISS2.
- ISS2: if !wb_valid, issue read r2 → CAP2; else stay.
- CAP2: capture d2 with the same rule using r2 → RSP.
- RSP:
  - rsp_valid=1; rsp_rs1_data=d1, rsp_rs2_data=d2.
  - Hold until rsp_ready → IDLE. req_ready=0 outside IDLE; no pipelining of requests.
- Bypass on held data:
  - In ISS2, CAP2 and RSP, a wb to r1 (r1!=0) overwrites d1.
  - In RSP, a wb to r2 (r2!=0) overwrites d2.
  - Writes in the rsp handshake cycle are not reflected.
- Guarantee: the response reflects every write accepted before the handshake cycle.
- rs1==rs2: both captures obey the same rules, giving identical values.
- Latency with no writebacks:
  - Accept at cycle N; rsp_valid at N+4.
  - Each wb-occupied ISS cycle adds one cycle.
  - A wb in CAP1 forces ISS2 and adds one cycle.
- Starvation: continuous wb_valid stalls reads indefinitely. This is accepted; the pipeline guarantees wb gaps.
- Reset (async, any state) → IDLE.
  - Reset values: rsp_valid=0, req_ready=1 once rst_n rises, rsp_rs1_data=0, rsp_rs2_data=0, d1=d2=0, sram_we=0.
  - An in-flight request is discarded with no response.

Decomposition:
- Package regfile_pkg:
  - State enum type rfc_state_t.
  - Constants RF_ADDR_WIDTH=5, RF_DATA_WIDTH=32, REG_ZERO='0.
- Single module; no sub-module. The capture/bypass mux is shared by CAP1/CAP2 via a function in the package.
- Bench instantiates the existing SRAM as the responder.

Test Plan:
- SRAM preloaded x3=0x11, x7=0x22; req rs1=3, rs2=7, no wb → rsp_valid at N+4, data 0x11/0x22; sram_we never 1.
- req rs1=0, rs2=0 while SRAM[0]=0xDEAD; wb to x0 with 0xBEEF → rsp 0/0; sram_we stays 0 on the x0 write.
- req rs1=5 (SRAM 0xAA); wb x5=0x55 in CAP1 cycle → rsp_rs1_data=0x55; SRAM[5]=0x55; rsp at N+5.
- wb_valid held high 3 cycles starting in ISS1 → no read issued while wb_valid; rsp at N+7 with correct data.
- Response held with rsp_ready=0; wb x7=0x99 in RSP → rsp_rs2_data becomes 0x99 next cycle; a later req for x7 also returns 0x99.
- rst_n pulled low in CAP2 → rsp_valid=0 and state IDLE immediately; new req after release returns correct data.
